// File: rtl/hall_call_panel.sv
// hall_call_panel: hall-side call front end for the lift controller.
// Synchronises the hall buttons, latches one call per landing and lights its
// lamp, serialises outstanding calls onto floorReq (4'b1111 = no request)
// round-robin, and retires a call when liftState reaches that landing.
// Optional build macro HALL_RESEND_EN adds a stall counter. When the car sits
// idle with sent calls still outstanding, the counter re-opens those calls
// for issue after RESEND_CYCLES.
module hall_call_panel #(
  parameter int NUM_FLOORS    = 11,
  parameter int RESEND_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_btn,
  input  logic [3:0]            liftState,
  input  logic [1:0]            motor_signal,
  output logic [3:0]            floorReq,
  output logic [NUM_FLOORS-1:0] call_lamp,
  output logic [3:0]            pending_cnt
);

  localparam logic [3:0] NO_REQ = 4'b1111;
  localparam int         IW     = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

  logic [NUM_FLOORS-1:0] sync1, sync2, prev;
  logic [NUM_FLOORS-1:0] pending, sent;
  logic [NUM_FLOORS-1:0] event_v, serve_v, cand, issue_v;
  logic [3:0]            rr, pick;
  logic                  pick_vld;
  logic                  resend_clr;

  // Two-flop synchroniser followed by a prev flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= hall_btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign event_v = sync2 & ~prev;

  // One-hot decode of the car position; out-of-range positions serve nothing
  always_comb begin
    serve_v = '0;
    for (int f = 0; f < NUM_FLOORS; f++) serve_v[f] = (liftState == 4'(f));
  end

  // The car's own floor is masked so serve and issue never collide
  assign cand = pending & ~sent & ~serve_v;

  // Round-robin search starting at rr, wrapping modulo NUM_FLOORS
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    issue_v  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      idx = int'(rr) + i;
      if (idx >= NUM_FLOORS) idx = idx - NUM_FLOORS;
      if (!pick_vld && cand[IW'(idx)]) begin
        pick_vld         = 1'b1;
        pick             = 4'(idx);
        issue_v[IW'(idx)] = 1'b1;
      end
    end
  end

`ifdef HALL_RESEND_EN
  localparam int CW = $clog2(RESEND_CYCLES + 1);

  logic [CW-1:0] stall_cnt;
  logic          stalled;

  // Counting only while the car is idle, nothing is being served and some
  // issued call is still waiting; the wrap re-opens every sent call.
  assign stalled    = (|(pending & sent)) && !(|(pending & serve_v)) &&
                      (motor_signal == 2'b00);
  assign resend_clr = stalled && (stall_cnt == CW'(RESEND_CYCLES - 2));

  // Stall counter: runs while stalled, clears on wrap or when not stalled
  always_ff @(posedge clk) begin
    if (rst || !stalled || resend_clr) stall_cnt <= '0;
    else                               stall_cnt <= stall_cnt + 1'b1;
  end
`else
  localparam int unused_resend_cycles = RESEND_CYCLES;
  logic unused_motor;
  assign unused_motor = ^motor_signal;
  assign resend_clr   = 1'b0;
`endif

  // Call bitmaps, round-robin pointer and registered request output
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      sent     <= '0;
      rr       <= '0;
      floorReq <= NO_REQ;
    end else begin
      pending  <= (pending | event_v) & ~serve_v;
      sent     <= ((resend_clr ? '0 : sent) & ~serve_v) | issue_v;
      floorReq <= pick_vld ? pick : NO_REQ;
      if (pick_vld) rr <= (pick == 4'(NUM_FLOORS - 1)) ? 4'd0 : pick + 4'd1;
    end
  end

  assign call_lamp = pending;

  // Lamp count straight from the pending register
  always_comb begin
    pending_cnt = '0;
    for (int f = 0; f < NUM_FLOORS; f++) pending_cnt = pending_cnt + 4'(pending[f]);
  end

endmodule

// File: tb/tb_hall_call_panel.sv
module tb_hall_call_panel;

  localparam int N  = 11;
  localparam int RC = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] hall_btn = '0;
  logic [3:0]   liftState = 4'd0;
  logic [1:0]   motor_signal = 2'b00;
  logic [3:0]   floorReq;
  logic [N-1:0] call_lamp;
  logic [3:0]   pending_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hall_call_panel #(.NUM_FLOORS(N), .RESEND_CYCLES(RC)) dut (
    .clk          (clk),
    .rst          (rst),
    .hall_btn     (hall_btn),
    .liftState    (liftState),
    .motor_signal (motor_signal),
    .floorReq     (floorReq),
    .call_lamp    (call_lamp),
    .pending_cnt  (pending_cnt)
  );

  // Behavioural reference: per-floor call flags, button sample history and a
  // round-robin pointer, updated from the rules once per rising edge.
  bit hist1[N], hist2[N], hist3[N];
  bit m_pend[N], m_sent[N];
  int m_rr, m_req, m_cnt;

  always @(posedge clk) begin : ref_model
    int  sf, pick, f;
    bit  outst, hit, reclr;
    bit  evt[N];
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        hist1[k] = 0; hist2[k] = 0; hist3[k] = 0; m_pend[k] = 0; m_sent[k] = 0;
      end
      m_rr = 0; m_req = 15; m_cnt = 0;
    end else begin
      sf = (int'(liftState) < N) ? int'(liftState) : -1;
      for (int k = 0; k < N; k++) evt[k] = hist2[k] && !hist3[k];
      pick = -1;
      for (int k = 0; k < N; k++) begin
        f = (m_rr + k) % N;
        if (pick < 0 && m_pend[f] && !m_sent[f] && f != sf) pick = f;
      end
      outst = 0;
      for (int k = 0; k < N; k++) if (m_pend[k] && m_sent[k]) outst = 1;
      hit   = (sf >= 0) && m_pend[sf];
      reclr = 0;
`ifdef HALL_RESEND_EN
      if (outst && !hit && motor_signal == 2'b00) begin
        if (m_cnt + 1 == RC - 1) begin m_cnt = 0; reclr = 1; end
        else m_cnt = m_cnt + 1;
      end else m_cnt = 0;
`endif
      for (int k = 0; k < N; k++) begin
        if (evt[k]) m_pend[k] = 1;
        if (reclr) m_sent[k] = 0;
        if (k == sf) begin m_pend[k] = 0; m_sent[k] = 0; end
        if (k == pick) m_sent[k] = 1;
      end
      m_req = (pick < 0) ? 15 : pick;
      if (pick >= 0) m_rr = (pick + 1) % N;
      for (int k = 0; k < N; k++) begin
        hist3[k] = hist2[k]; hist2[k] = hist1[k]; hist1[k] = hall_btn[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (floorReq !== 4'hF) begin failures++; $display("FAIL reset_floorReq got=%h exp=f", floorReq); end
    checks++; if (call_lamp !== '0) begin failures++; $display("FAIL reset_lamp got=%h exp=0", call_lamp); end
    checks++; if (pending_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single_call();
    liftState = 4'd0;
    hall_btn = '0; hall_btn[5] = 1'b1;
    tick();                     // edge 0
    hall_btn = '0;
    tick();                     // edge 1
    checks++; if (call_lamp !== '0) begin failures++; $display("FAIL single_lamp_e1 got=%h exp=0", call_lamp); end
    tick();                     // edge 2
    checks++; if (call_lamp !== 11'h020) begin failures++; $display("FAIL single_lamp_e2 got=%h exp=020", call_lamp); end
    checks++; if (floorReq !== 4'hF) begin failures++; $display("FAIL single_req_e2 got=%h exp=f", floorReq); end
    tick();                     // edge 3
    checks++; if (floorReq !== 4'd5) begin failures++; $display("FAIL single_req_e3 got=%h exp=5", floorReq); end
    tick();                     // edge 4
    checks++; if (floorReq !== 4'hF) begin failures++; $display("FAIL single_req_e4 got=%h exp=f", floorReq); end
    checks++; if (pending_cnt !== 4'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", pending_cnt); end
    liftState = 4'd5;
    tick();
    checks++; if (call_lamp !== '0) begin failures++; $display("FAIL single_serve_lamp got=%h exp=0", call_lamp); end
    checks++; if (pending_cnt !== 4'd0) begin failures++; $display("FAIL single_serve_cnt got=%0d exp=0", pending_cnt); end
    liftState = 4'd0;
    tick();
  endtask

  task automatic test_multi_call();
    int exp_seq[4] = '{2, 7, 9, 15};
    int serve_f[3] = '{2, 7, 9};
    rst = 1'b1; tick(); rst = 1'b0;
    liftState = 4'd0;
    hall_btn = 11'h284;
    tick();
    hall_btn = '0;
    tick(); tick();
    checks++; if (call_lamp !== 11'h284) begin failures++; $display("FAIL multi_lamp got=%h exp=284", call_lamp); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (floorReq !== 4'(exp_seq[i])) begin
        failures++; $display("FAIL multi_seq[%0d] got=%h exp=%h", i, floorReq, 4'(exp_seq[i]));
      end
    end
    checks++; if (pending_cnt !== 4'd3) begin failures++; $display("FAIL multi_cnt got=%0d exp=3", pending_cnt); end
    for (int i = 0; i < 3; i++) begin liftState = 4'(serve_f[i]); tick(); end
    checks++; if (pending_cnt !== 4'd0) begin failures++; $display("FAIL multi_served_cnt got=%0d exp=0", pending_cnt); end
    liftState = 4'd0;
    tick();
  endtask

  task automatic test_drop_and_hold();
    int n6;
    int exp6;
    liftState = 4'd4;
    hall_btn = '0; hall_btn[4] = 1'b1;
    tick();
    hall_btn = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (call_lamp !== '0) begin failures++; $display("FAIL drop_lamp[%0d] got=%h exp=0", i, call_lamp); end
      checks++; if (floorReq !== 4'hF) begin failures++; $display("FAIL drop_req[%0d] got=%h exp=f", i, floorReq); end
    end
    liftState = 4'd0;
    hall_btn[6] = 1'b1;
    n6 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (floorReq === 4'd6) n6++;
    end
    hall_btn = '0;
`ifdef HALL_RESEND_EN
    exp6 = 3;                   // first issue at edge 3, re-issued every RC cycles
`else
    exp6 = 1;
`endif
    checks++; if (n6 != exp6) begin failures++; $display("FAIL hold_issue_count got=%0d exp=%0d", n6, exp6); end
    liftState = 4'd6; tick();
    liftState = 4'd0; tick();
    checks++; if (call_lamp !== '0) begin failures++; $display("FAIL hold_served_lamp got=%h exp=0", call_lamp); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    liftState = 4'd0;
    hall_btn = '0; hall_btn[8] = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (floorReq === 4'd8) begin seen = 1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL midrst_issue timeout got=0 exp=1"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (call_lamp !== '0) begin failures++; $display("FAIL midrst_lamp got=%h exp=0", call_lamp); end
    checks++; if (floorReq !== 4'hF) begin failures++; $display("FAIL midrst_req got=%h exp=f", floorReq); end
    tick(); tick();
    checks++; if (call_lamp[8] !== 1'b0) begin failures++; $display("FAIL midrst_lamp_r2 got=%b exp=0", call_lamp[8]); end
    tick();
    checks++; if (call_lamp[8] !== 1'b1) begin failures++; $display("FAIL midrst_lamp_r3 got=%b exp=1", call_lamp[8]); end
    hall_btn = '0;
    liftState = 4'd8; tick();
    liftState = 4'd0; tick();
  endtask

  task automatic test_resend();
    int n3;
    int first;
    rst = 1'b1; tick(); rst = 1'b0;
    liftState = 4'd0; motor_signal = 2'b00;
    hall_btn = '0; hall_btn[3] = 1'b1;
    tick();
    hall_btn = '0;
    tick(); tick(); tick();     // edge 3
    checks++; if (floorReq !== 4'd3) begin failures++; $display("FAIL resend_first got=%h exp=3", floorReq); end
    n3 = 0; first = -1;
    for (int e = 4; e <= 14; e++) begin
      tick();
      if (floorReq === 4'd3) begin n3++; if (first < 0) first = e; end
    end
`ifdef HALL_RESEND_EN
    checks++; if (n3 != 1) begin failures++; $display("FAIL resend_count got=%0d exp=1", n3); end
    checks++; if (first != 3 + RC) begin failures++; $display("FAIL resend_edge got=%0d exp=%0d", first, 3 + RC); end
`else
    checks++; if (n3 != 0) begin failures++; $display("FAIL resend_count got=%0d exp=0", n3); end
`endif
    checks++; if (call_lamp !== 11'h008) begin failures++; $display("FAIL resend_lamp got=%h exp=008", call_lamp); end
    liftState = 4'd3; tick();
    liftState = 4'd0; tick();
  endtask

  task automatic test_serve_vs_press();
    liftState = 4'd0;
    hall_btn = '0; hall_btn[2] = 1'b1;
    tick();
    hall_btn = '0;
    tick(); tick(); tick();
    checks++; if (floorReq !== 4'd2) begin failures++; $display("FAIL svp_first got=%h exp=2", floorReq); end
    hall_btn[2] = 1'b1;
    tick();
    hall_btn = '0;
    tick();
    liftState = 4'd2;           // serve lands on the same edge as the new event
    tick();
    checks++; if (call_lamp[2] !== 1'b0) begin failures++; $display("FAIL svp_lamp got=%b exp=0", call_lamp[2]); end
    liftState = 4'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (floorReq === 4'd2) begin failures++; $display("FAIL svp_req[%0d] got=2 exp=not 2", i); end
      checks++; if (call_lamp[2] !== 1'b0) begin failures++; $display("FAIL svp_lamp[%0d] got=%b exp=0", i, call_lamp[2]); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] el;
    int           ec;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      hall_btn = hall_btn ^ N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) liftState = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 499) == 0);
      tick();
      el = '0; ec = 0;
      for (int k = 0; k < N; k++) begin el[k] = m_pend[k]; ec += int'(m_pend[k]); end
      checks++; if (floorReq !== 4'(m_req)) begin failures++; $display("FAIL rand_req[%0d] got=%h exp=%h", c, floorReq, 4'(m_req)); end
      checks++; if (call_lamp !== el) begin failures++; $display("FAIL rand_lamp[%0d] got=%h exp=%h", c, call_lamp, el); end
      checks++; if (pending_cnt !== 4'(ec)) begin failures++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", c, pending_cnt, ec); end
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_call();
    test_multi_call();
    test_drop_and_hold();
    test_reset_mid();
    test_resend();
    test_serve_vs_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hall_call_panel.md
# hall_call_panel

Hall-side call front end for the `lift` controller. Samples the per-floor hall call buttons, synchronises them, and latches each call with a lamp. Serialises outstanding calls onto the lift's `floorReq` encoding, one floor per cycle, with `4'b1111` as the no-request code. Watches `liftState` to retire each call when the car reaches that floor.

## Interface
- `NUM_FLOORS`, 11: number of landings (floors 0..NUM_FLOORS-1); must be ≤ 15 so 4'b1111 stays free.
- `RESEND_CYCLES`, 64: stall timeout before outstanding calls are re-issued (only with `HALL_RESEND_EN`).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hall_btn` in NUM_FLOORS: raw hall buttons, bit f = floor f, asynchronous, level.
- `liftState` in 4: current car floor from `lift`.
- `motor_signal` in 2: lift motor state (00 idle, 11 up, 10 down); used only for the idle-stall check.
- `floorReq` out 4 (registered): floor index for one cycle, else 4'b1111.
- `call_lamp` out NUM_FLOORS (registered): bit f high while the call at floor f is outstanding.
- `pending_cnt` out 4: popcount of `call_lamp`.

## Operation
- **Input path:** each `hall_btn` bit passes through a 2-flop synchroniser (s1, s2), then a prev flop. A call event is s2 & ~prev, so one press gives exactly one event. Holding a button gives no further events.
- **State bitmaps:** `pending[f]` drives `call_lamp`. `sent[f]` means floor f has been put on `floorReq`.
- **New call:** an event at f sets `pending[f]` only if it is not already set and `liftState != f`. A press at the car's current floor is dropped.
- **Serve:** when `liftState == f` and `f < NUM_FLOORS`, clear `pending[f]` and `sent[f]` on that edge, whether the car is moving or stopped. This matches the lift clearing its request when passing. `liftState ≥ NUM_FLOORS` serves nothing.
- **Arbiter:** round-robin over `pending & ~sent & ~(floor==liftState)`.
  - Search starts at pointer `rr`, wraps modulo NUM_FLOORS, and picks the first hit.
  - On issue: `floorReq <= f`, `sent[f] <= 1`, `rr <= (f+1) mod NUM_FLOORS`.
  - No candidate: `floorReq <= 4'b1111`.
  - One issue per cycle; back-to-back issues of different floors are legal. The lift needs no handshake because it samples every cycle.
- **Simultaneous events:**
  - Serve and a new event at the same floor: serve wins, and the call stays clear.
  - Serve and issue in the same cycle must target different floors, which the arbiter mask guarantees.

## Timing
- **Reset values:** `floorReq = 4'b1111`, `call_lamp = 0`, `pending_cnt = 0`. `rr`, sync/prev flops, `sent` and the resend counter are all 0.
- **Press latency:** let edge 0 be the first edge sampling `hall_btn[f]` high.
  - s2 goes high after edge 1.
  - `call_lamp[f]` goes high after edge 2.
  - Earliest `floorReq == f` is after edge 3, held for exactly one cycle.
- **Serve latency:** `call_lamp[f]` falls on the first edge at which `liftState == f` is sampled.
- **`pending_cnt`** tracks `call_lamp` with no extra delay, since it is computed from the `pending` register.
- **Reset mid-operation:** all calls and lamps are dropped with no `floorReq` output. A button held through reset is treated as a new press: lamp high after the 3rd edge following reset release.

## Configuration
- **`HALL_RESEND_EN` defined:** a stall counter increments each cycle while `pending & sent != 0` and no serve occurs.
  - The counter resets to 0 on any serve, or when nothing is outstanding.
  - On reaching `RESEND_CYCLES-1`, all `sent` bits are cleared and the counter returns to 0, so outstanding calls re-enter round-robin issue.
  - This recovers calls the lift missed while `motor_signal` stays 00.
- **Not defined:** no counter exists, and each call is issued exactly once per press.

## Test plan
- Reset, then pulse `hall_btn[5]` with `liftState = 0` → `call_lamp[5] = 1` after edge 2, `floorReq = 5` for one cycle after edge 3, then 4'b1111, `pending_cnt = 1`. Drive `liftState = 5` → lamp clears on that edge, `pending_cnt = 0`.
- Press floors 2, 7 and 9 on the same cycle with `rr = 0` → `floorReq` sequence 2, 7, 9 on consecutive cycles, then 4'b1111, `pending_cnt = 3`.
- Car at floor 4, press `hall_btn[4]` → no lamp and no `floorReq`. Hold `hall_btn[6]` for 20 cycles → exactly one `floorReq = 6`.
- Call at floor 8 outstanding and sent, assert `rst` for 1 cycle while `hall_btn[8]` is held → lamp 0 and `floorReq = 4'b1111` after the reset edge. Lamp 8 returns after the 3rd edge following release.
- `HALL_RESEND_EN` with `RESEND_CYCLES = 8`: issue floor 3, keep `liftState = 0` and `motor_signal = 00` → `floorReq = 3` again 8 cycles after the first issue. With the macro undefined → issued once only.
- Serve floor 2 and new press at floor 2 on the same edge → `call_lamp[2] = 0`, no `floorReq = 2`.
